// File: rtl/unit_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : unit_fetch                                                      |
// | Brief    : MIPS instruction-fetch stage: PC, IF/ID register, redirect and  |
// |            flush, halt FSM. Optional statistics via UNIT_FETCH_STATS_EN.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module unit_fetch #(
  parameter int          NB_INSTR    = 32,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111,
  parameter int          ADDRWIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic                 stall_i,
  input  logic [NB_INSTR-1:0]  instr_i,
  input  logic                 branch_eq_i,
  input  logic                 branch_ne_i,
  input  logic                 is_equal_i,
  input  logic [ADDRWIDTH-1:0] branch_address_i,
  input  logic                 jump_i,
  input  logic [ADDRWIDTH-1:0] jump_address_i,
  input  logic                 jump_reg_i,
  input  logic [ADDRWIDTH-1:0] jump_reg_address_i,
  output logic [ADDRWIDTH-1:0] pc_o,
  output logic [ADDRWIDTH-1:0] pc_plus1_ifid_o,
  output logic [NB_INSTR-1:0]  instr_ifid_o,
  output logic                 valid_ifid_o,
  output logic                 flush_o,
  output logic                 halted_o,
  output logic [31:0]          redirect_count_o,
  output logic [31:0]          stall_count_o
);

  localparam logic [ADDRWIDTH-1:0] c_PC_ONE = ADDRWIDTH'(1);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDRWIDTH-1:0]   r_pc;
  logic [ADDRWIDTH-1:0]   w_pc_next;
  logic [ADDRWIDTH-1:0]   r_pc_plus1_ifid;
  logic [ADDRWIDTH-1:0]   w_pc_plus1_ifid_next;
  logic [NB_INSTR-1:0]    r_instr_ifid;
  logic [NB_INSTR-1:0]    w_instr_ifid_next;
  logic                   r_valid_ifid;
  logic                   w_valid_ifid_next;

  logic                   w_advance;
  logic                   w_taken;
  logic                   w_flush;
  logic                   w_is_halt;
  logic [ADDRWIDTH-1:0]   w_target;
  logic [ADDRWIDTH-1:0]   w_pc_plus1;

  assign w_advance  = enable_i & ~stall_i;
  assign w_taken    = r_valid_ifid & ((branch_eq_i & is_equal_i) |
                                      (branch_ne_i & ~is_equal_i) |
                                      jump_i | jump_reg_i);
  // Once halted, whatever sits in ID can no longer steer fetch.
  assign w_flush    = w_taken & w_advance & (r_state == ST_RUN);
  assign w_is_halt  = (instr_i[NB_INSTR-1:NB_INSTR-6] == HALT_OPCODE);
  assign w_pc_plus1 = r_pc + c_PC_ONE;
  assign w_target   = jump_reg_i ? jump_reg_address_i :
                      jump_i     ? jump_address_i     :
                                   branch_address_i;

  always_comb begin
    w_state_next         = r_state;
    w_pc_next            = r_pc;
    w_pc_plus1_ifid_next = r_pc_plus1_ifid;
    w_instr_ifid_next    = r_instr_ifid;
    w_valid_ifid_next    = r_valid_ifid;
    if (w_advance) begin
      if (r_state == ST_RUN) begin
        if (w_flush) begin
          // Redirect wins even over a halt fetched on the wrong path.
          w_pc_next            = w_target;
          w_pc_plus1_ifid_next = '0;
          w_instr_ifid_next    = '0;
          w_valid_ifid_next    = 1'b0;
        end else if (w_is_halt) begin
          w_pc_plus1_ifid_next = w_pc_plus1;
          w_instr_ifid_next    = instr_i;
          w_valid_ifid_next    = 1'b1;
          w_state_next         = ST_HALTED;
        end else begin
          w_pc_next            = w_pc_plus1;
          w_pc_plus1_ifid_next = w_pc_plus1;
          w_instr_ifid_next    = instr_i;
          w_valid_ifid_next    = 1'b1;
        end
      end else begin
        w_pc_plus1_ifid_next = '0;
        w_instr_ifid_next    = '0;
        w_valid_ifid_next    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state         <= ST_RUN;
      r_pc            <= '0;
      r_pc_plus1_ifid <= '0;
      r_instr_ifid    <= '0;
      r_valid_ifid    <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_pc            <= w_pc_next;
      r_pc_plus1_ifid <= w_pc_plus1_ifid_next;
      r_instr_ifid    <= w_instr_ifid_next;
      r_valid_ifid    <= w_valid_ifid_next;
    end
  end

`ifdef UNIT_FETCH_STATS_EN
  logic [31:0] r_redirect_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_redirect_count <= '0;
      r_stall_count    <= '0;
    end else begin
      if (w_flush) begin
        r_redirect_count <= r_redirect_count + 32'd1;
      end
      if (enable_i & stall_i) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign redirect_count_o = r_redirect_count;
  assign stall_count_o    = r_stall_count;
`else
  assign redirect_count_o = 32'd0;
  assign stall_count_o    = 32'd0;
`endif

  assign pc_o            = r_pc;
  assign pc_plus1_ifid_o = r_pc_plus1_ifid;
  assign instr_ifid_o    = r_instr_ifid;
  assign valid_ifid_o    = r_valid_ifid;
  assign flush_o         = w_flush;
  assign halted_o        = (r_state == ST_HALTED);

endmodule

`default_nettype wire
